// File: rtl/spk_out_encoder.sv
// Outbound packet encoder: turns fired-neuron addresses into SPIKE packets carrying global
// (x,y,z) coordinates, and streams soma memory words out as DATA/DATA_END packets on request.
module spk_out_encoder #(
    parameter int NNW = 12,
    parameter int SW  = 24,
    parameter int FTW = 3,
    parameter int FAW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            soma_spk_vld,
    input  logic [NNW-1:0]  soma_spk_addr,
    output logic            spk_busy,
    output logic            spk_ovf,
    input  logic            rd_start,
    input  logic [NNW-1:0]  rd_len,
    output logic            out_soma_re,
    output logic [NNW-1:0]  out_soma_raddr,
    input  logic [SW-1:0]   soma_out_rdata,
    output logic            spk_out_vld,
    output logic [SW-1:0]   spk_out_data,
    output logic [FTW-1:0]  spk_out_type,
    input  logic            spk_out_rdy,
    input  logic [NNW-1:0]  x_out,
    input  logic [NNW-1:0]  y_out,
    input  logic [NNW-1:0]  xy_out,
    input  logic [SW/3-1:0] x_start,
    input  logic [SW/3-1:0] y_start,
    output logic [2:0]      dbg_state
);
    localparam int CW    = SW / 3;
    localparam int DEPTH = 1 << FAW;
    localparam logic [FTW-1:0] T_SPIKE = FTW'(0);
    localparam logic [FTW-1:0] T_DATA  = FTW'(1);
    localparam logic [FTW-1:0] T_END   = FTW'(2);

    typedef enum logic [2:0] {S_IDLE, S_DIV_Z, S_DIV_Y, S_SEND, S_RD_REQ, S_RD_SEND} state_t;

    state_t         state_q, state_d;
    logic [NNW-1:0] fifo_q [DEPTH];
    logic [FAW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FAW:0]   count_q, count_d;
    logic           ovf_q, ovf_d, rd_pend_q, rd_pend_d;
    logic [NNW-1:0] len_hold_q, len_hold_d, idx_q, idx_d;
    logic [NNW-1:0] rem_q, rem_d, zc_q, zc_d, yc_q, yc_d;
    logic           vld_q, vld_d, re_q, re_d;
    logic [SW-1:0]  data_q, data_d;
    logic [FTW-1:0] type_q, type_d;
    logic [NNW-1:0] raddr_q, raddr_d;
    logic           push, pop;
    logic [CW-1:0]  z_f, y_f, x_f;
    logic           unused_cfg;

    // y_out only matters through xy_out; it is kept on the port for geometry completeness.
    assign unused_cfg = ^y_out;

    assign spk_busy       = (count_q == (FAW+1)'(DEPTH));
    assign spk_ovf        = ovf_q;
    assign out_soma_re    = re_q;
    assign out_soma_raddr = raddr_q;
    assign spk_out_vld    = vld_q;
    assign spk_out_data   = data_q;
    assign spk_out_type   = type_q;
    assign dbg_state      = state_q;

    // Output handshake: a packet transfers on a cycle where spk_out_vld and spk_out_rdy are both
    // high; while vld is high and rdy low, data and type hold; vld drops the cycle after transfer.
    always_comb begin
        push       = soma_spk_vld && !spk_busy;
        pop        = (state_q == S_SEND) && spk_out_rdy;
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q + FAW'(push);
        rd_ptr_d   = rd_ptr_q + FAW'(pop);
        count_d    = count_q + (FAW+1)'(push) - (FAW+1)'(pop);
        ovf_d      = ovf_q | (soma_spk_vld && spk_busy);
        rd_pend_d  = rd_pend_q;
        len_hold_d = len_hold_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        zc_d       = zc_q;
        yc_d       = yc_q;
        vld_d      = vld_q;
        data_d     = data_q;
        type_d     = type_q;
        re_d       = 1'b0;
        raddr_d    = '0;
        z_f        = CW'(zc_q);
        y_f        = CW'(yc_q) + y_start;
        x_f        = CW'(rem_q) + x_start;

        if (rd_start && !rd_pend_q && state_q != S_RD_REQ && state_q != S_RD_SEND) begin
            rd_pend_d  = 1'b1;
            len_hold_d = rd_len;
        end

        case (state_q)
            S_IDLE: begin
                if (rd_pend_q) begin
                    rd_pend_d = 1'b0;
                    if (len_hold_q != '0) begin
                        idx_d   = '0;
                        re_d    = 1'b1;
                        state_d = S_RD_REQ;
                    end
                end else if (count_q != '0) begin
                    rem_d   = fifo_q[rd_ptr_q];
                    zc_d    = '0;
                    yc_d    = '0;
                    state_d = S_DIV_Z;
                end
            end
            S_DIV_Z: begin
                if (xy_out != '0 && rem_q >= xy_out) begin
                    rem_d = rem_q - xy_out;
                    zc_d  = zc_q + NNW'(1);
                end else begin
                    state_d = S_DIV_Y;
                end
            end
            S_DIV_Y: begin
                if (x_out != '0 && rem_q >= x_out) begin
                    rem_d = rem_q - x_out;
                    yc_d  = yc_q + NNW'(1);
                end else begin
                    vld_d   = 1'b1;
                    type_d  = T_SPIKE;
                    data_d  = SW'({z_f, y_f, x_f});
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (spk_out_rdy) begin
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_RD_REQ: begin
                state_d = S_RD_SEND;
            end
            S_RD_SEND: begin
                // First cycle here: read data is on soma_out_rdata, capture it as the packet.
                if (!vld_q) begin
                    vld_d  = 1'b1;
                    data_d = soma_out_rdata;
                    type_d = (idx_q == len_hold_q - NNW'(1)) ? T_END : T_DATA;
                end else if (spk_out_rdy) begin
                    vld_d = 1'b0;
                    if (type_q == T_END) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + NNW'(1);
                        re_d    = 1'b1;
                        raddr_d = idx_q + NNW'(1);
                        state_d = S_RD_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rd_pend_q  <= 1'b0;
            len_hold_q <= '0;
            idx_q      <= '0;
            rem_q      <= '0;
            zc_q       <= '0;
            yc_q       <= '0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            type_q     <= '0;
            re_q       <= 1'b0;
            raddr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            rd_pend_q  <= rd_pend_d;
            len_hold_q <= len_hold_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            zc_q       <= zc_d;
            yc_q       <= yc_d;
            vld_q      <= vld_d;
            data_q     <= data_d;
            type_q     <= type_d;
            re_q       <= re_d;
            raddr_q    <= raddr_d;
            if (push) fifo_q[wr_ptr_q] <= soma_spk_addr;
        end
    end
endmodule

// File: tb/tb_spk_out_encoder.sv
// Bench for spk_out_encoder: directed vectors, a division-based packet model and a per-cycle
// monitor that checks every accepted packet, read request, hold and busy/overflow flag.
module tb_spk_out_encoder;
    localparam int NNW = 12;
    localparam int SW  = 24;
    localparam int FTW = 3;
    localparam int FAW = 3;
    localparam int CW  = SW / 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           soma_spk_vld = 1'b0;
    logic [NNW-1:0] soma_spk_addr = '0;
    logic           spk_busy, spk_ovf;
    logic           rd_start = 1'b0;
    logic [NNW-1:0] rd_len = '0;
    logic           out_soma_re;
    logic [NNW-1:0] out_soma_raddr;
    logic [SW-1:0]  soma_out_rdata = '0;
    logic           spk_out_vld;
    logic [SW-1:0]  spk_out_data;
    logic [FTW-1:0] spk_out_type;
    logic           spk_out_rdy = 1'b0;
    logic [NNW-1:0] x_out = '0, y_out = '0, xy_out = '0;
    logic [CW-1:0]  x_start = '0, y_start = '0;
    logic [2:0]     dbg_state;

    spk_out_encoder #(.NNW(NNW), .SW(SW), .FTW(FTW), .FAW(FAW)) dut (
        .clk(clk), .rst_n(rst_n),
        .soma_spk_vld(soma_spk_vld), .soma_spk_addr(soma_spk_addr),
        .spk_busy(spk_busy), .spk_ovf(spk_ovf),
        .rd_start(rd_start), .rd_len(rd_len),
        .out_soma_re(out_soma_re), .out_soma_raddr(out_soma_raddr),
        .soma_out_rdata(soma_out_rdata),
        .spk_out_vld(spk_out_vld), .spk_out_data(spk_out_data), .spk_out_type(spk_out_type),
        .spk_out_rdy(spk_out_rdy),
        .x_out(x_out), .y_out(y_out), .xy_out(xy_out),
        .x_start(x_start), .y_start(y_start),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // soma memory: word at address a is a + 0x100, returned one cycle after the read enable
    always @(posedge clk) begin
        if (out_soma_re) soma_out_rdata <= SW'(out_soma_raddr) + SW'(32'h100);
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // scoreboard state
    logic [SW-1:0]      spk_q[$];
    logic [FTW+SW-1:0]  exp_q[$];
    logic [NNW-1:0]     raddr_q[$];
    logic [FTW-1:0]     type_log[$];
    logic               exp_ovf = 1'b0;
    int                 acc_cnt = 0;
    int                 re_cnt = 0;

    function automatic logic [SW-1:0] spike_model(input int addr);
        int z, r, y, x;
        z = (xy_out != 0) ? addr / int'(xy_out) : 0;
        r = (xy_out != 0) ? addr % int'(xy_out) : addr;
        y = (x_out != 0) ? r / int'(x_out) : 0;
        x = (x_out != 0) ? r % int'(x_out) : r;
        return {CW'(z), CW'(y + int'(y_start)), CW'(x + int'(x_start))};
    endfunction

    // monitor: one compare process sampling mid-cycle
    logic           p_vld = 1'b0, p_rdy = 1'b0, p_re = 1'b0;
    logic [SW-1:0]  p_data = '0;
    logic [FTW-1:0] p_type = '0;
    logic           m_full;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_vld = 1'b0;
            p_rdy = 1'b0;
            p_re  = 1'b0;
        end else begin
            m_full = (spk_q.size() == (1 << FAW));
            check("busy", spk_busy, m_full);
            check("ovf", spk_ovf, exp_ovf);
            if (soma_spk_vld) begin
                if (m_full) exp_ovf = 1'b1;
                else spk_q.push_back(spike_model(int'(soma_spk_addr)));
            end
            if (p_vld && !p_rdy) begin
                check("hold_vld", spk_out_vld, 1);
                check("hold_data", spk_out_data, p_data);
                check("hold_type", spk_out_type, p_type);
            end
            if (p_vld && p_rdy) check("vld_drop", spk_out_vld, 0);
            if (spk_out_vld && spk_out_rdy) begin
                acc_cnt++;
                type_log.push_back(spk_out_type);
                if (spk_out_type == '0) begin
                    check("spike_expected", spk_q.size() != 0, 1);
                    if (spk_q.size() != 0) check("spike_pkt", spk_out_data, spk_q.pop_front());
                end else begin
                    check("data_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("data_pkt", {spk_out_type, spk_out_data}, exp_q.pop_front());
                end
            end
            if (out_soma_re) begin
                re_cnt++;
                check("re_one_cycle", p_re, 0);
                check("re_expected", raddr_q.size() != 0, 1);
                if (raddr_q.size() != 0) check("raddr", out_soma_raddr, raddr_q.pop_front());
            end
            p_vld  = spk_out_vld;
            p_rdy  = spk_out_rdy;
            p_re   = out_soma_re;
            p_data = spk_out_data;
            p_type = spk_out_type;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int x, input int y, input int xs, input int ys);
        x_out = NNW'(x);
        y_out = NNW'(y);
        xy_out = NNW'(x * y);
        x_start = CW'(xs);
        y_start = CW'(ys);
    endtask

    task automatic push_spike(input int addr);
        soma_spk_vld = 1'b1;
        soma_spk_addr = NNW'(addr);
        tick();
        soma_spk_vld = 1'b0;
    endtask

    task automatic request_read(input int len);
        rd_start = 1'b1;
        rd_len = NNW'(len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1) ? 3'd2 : 3'd1, SW'(i + 32'h100)});
            raddr_q.push_back(NNW'(i));
        end
        tick();
        rd_start = 1'b0;
    endtask

    task automatic wait_vld(input string name, input int budget);
        int n;
        n = 0;
        while (!spk_out_vld && n < budget) begin
            tick();
            n++;
        end
        check(name, spk_out_vld, 1);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && !(spk_q.size() == 0 && exp_q.size() == 0 && raddr_q.size() == 0
                               && dbg_state == 3'd0 && !spk_out_vld)) begin
            tick();
            n++;
        end
        check(name, n < budget, 1);
    endtask

    initial begin
        int edges, acc0, re0, seq;
        #500000;
        $display("FAIL watchdog: bench did not finish (checks %0d)", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int edges, acc0, re0, seq;
        // reset state
        repeat (3) tick();
        check("rst_vld", spk_out_vld, 0);
        check("rst_busy", spk_busy, 0);
        check("rst_ovf", spk_ovf, 0);
        check("rst_re", out_soma_re, 0);
        check("rst_data", spk_out_data, 0);
        check("rst_type", spk_out_type, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        tick();

        // spike decode with two extra subtractions: latency 6 edges
        set_cfg(4, 4, 2, 1);
        spk_out_rdy = 1'b1;
        soma_spk_vld = 1'b1;
        soma_spk_addr = NNW'(21);
        tick();
        soma_spk_vld = 1'b0;
        edges = 1;
        while (!spk_out_vld && edges < 50) begin
            tick();
            edges++;
        end
        check("lat_addr21", edges, 6);
        check("data_addr21", spk_out_data, 24'h010203);
        check("type_addr21", spk_out_type, 0);
        drain("drain_addr21", 50);

        // address below x_out: latency 4 edges
        soma_spk_vld = 1'b1;
        soma_spk_addr = NNW'(3);
        tick();
        soma_spk_vld = 1'b0;
        edges = 1;
        while (!spk_out_vld && edges < 50) begin
            tick();
            edges++;
        end
        check("lat_addr3", edges, 4);
        check("data_addr3", spk_out_data, 24'h000105);
        drain("drain_addr3", 50);

        // backpressure
        spk_out_rdy = 1'b0;
        acc0 = acc_cnt;
        push_spike(0);
        wait_vld("bp_vld", 20);
        check("bp_data", spk_out_data, 24'h000102);
        repeat (5) tick();
        check("bp_still_vld", spk_out_vld, 1);
        spk_out_rdy = 1'b1;
        drain("drain_bp", 50);
        check("bp_one_accept", acc_cnt - acc0, 1);
        check("bp_busy_after", spk_busy, 0);

        // overflow: 9 back-to-back events, ninth dropped
        spk_out_rdy = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i == 8) check("busy_before_8th", spk_busy, 0);
            if (i == 9) check("busy_before_9th", spk_busy, 1);
            soma_spk_vld = 1'b1;
            soma_spk_addr = NNW'(i);
            tick();
        end
        soma_spk_vld = 1'b0;
        tick();
        check("ovf_busy", spk_busy, 1);
        check("ovf_sticky", spk_ovf, 1);
        acc0 = acc_cnt;
        spk_out_rdy = 1'b1;
        drain("drain_ovf", 300);
        check("ovf_eight_pkts", acc_cnt - acc0, 8);
        check("ovf_still_set", spk_ovf, 1);

        // readout of 3 words with initial backpressure
        spk_out_rdy = 1'b0;
        re0 = re_cnt;
        acc0 = acc_cnt;
        request_read(3);
        repeat (6) tick();
        spk_out_rdy = 1'b1;
        drain("drain_rd", 100);
        check("rd_re_count", re_cnt - re0, 3);
        check("rd_pkt_count", acc_cnt - acc0, 3);

        // readout has priority over queued spikes
        type_log.delete();
        soma_spk_vld = 1'b1;
        soma_spk_addr = NNW'(5);
        request_read(3);
        soma_spk_addr = NNW'(6);
        tick();
        soma_spk_vld = 1'b0;
        drain("drain_prio", 200);
        seq = 0;
        foreach (type_log[i]) seq = seq * 8 + int'(type_log[i]);
        check("prio_count", type_log.size(), 5);
        check("prio_order", seq, 4736);

        // zero-length readout: no request, no packet, then spikes still flow
        re0 = re_cnt;
        acc0 = acc_cnt;
        request_read(0);
        repeat (10) tick();
        check("zlen_no_re", re_cnt - re0, 0);
        check("zlen_no_pkt", acc_cnt - acc0, 0);
        push_spike(7);
        drain("drain_zlen", 50);
        check("zlen_then_spike", acc_cnt - acc0, 1);

        // zero divisors, then reset in the middle of SEND
        set_cfg(0, 0, 0, 0);
        spk_out_rdy = 1'b0;
        push_spike(5);
        push_spike(9);
        wait_vld("zdiv_vld", 30);
        check("zdiv_data", spk_out_data, 24'h000005);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", spk_out_vld, 0);
        check("mid_rst_busy", spk_busy, 0);
        check("mid_rst_ovf", spk_ovf, 0);
        spk_q.delete();
        exp_q.delete();
        raddr_q.delete();
        exp_ovf = 1'b0;
        tick();
        rst_n = 1'b1;
        spk_out_rdy = 1'b1;
        acc0 = acc_cnt;
        repeat (20) tick();
        check("no_replay", acc_cnt - acc0, 0);
        check("idle_after_rst", dbg_state, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spk_out_encoder.md
Name: spk_out_encoder

Overview:
- Transmit side of the node's spike-packet interface. Converts fired-neuron addresses from the soma into SPIKE packets carrying (x,y,z) coordinates in the global layer frame.
- On request, streams soma memory words out as DATA packets, with DATA_END marking the last word.
- Sits between the soma and the router/outbound packet port. It produces the packet format that the inbound axon logic consumes.

Parameters:
- NNW, 12, neuron address / geometry width
- SW, 24, packet payload width (three SW/3 coordinate fields)
- FTW, 3, packet type width
- FAW, 3, spike FIFO address width (depth 2**FAW)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- soma_spk_vld  in  1  fired-neuron event
- soma_spk_addr  in  NNW  linear local neuron address of the firing
- spk_busy  out  1  spike FIFO full; events presented while high are dropped
- spk_ovf  out  1  sticky: an event was dropped
- rd_start  in  1  one-cycle request for a memory readout
- rd_len  in  NNW  number of words to read, sampled with rd_start
- out_soma_re  out  1  soma read enable
- out_soma_raddr  out  NNW  soma read address
- soma_out_rdata  in  SW  soma read data, valid one cycle after out_soma_re
- spk_out_vld  out  1  packet valid
- spk_out_data  out  SW  packet payload
- spk_out_type  out  FTW  packet type: SPIKE=000, DATA=001, DATA_END=010
- spk_out_rdy  in  1  downstream accept
- x_out, y_out, xy_out  in  NNW each  local output geometry; xy_out = x_out*y_out
- x_start, y_start  in  SW/3 each  global offset of the local tile

Behaviour:
- Reset values: every output and register is 0, the FSM is in IDLE, the FIFO is empty, and rd_pend and spk_ovf are 0.
- FIFO push:
  - Push when soma_spk_vld && !spk_busy.
  - spk_busy = (count == 2**FAW), computed from the registered count.
  - A push while full is refused even if a pop occurs in the same cycle. The refused event is dropped and sets spk_ovf.
- Readout request:
  - rd_start sets rd_pend and latches rd_len into len_hold.
  - rd_start arriving while a readout is already pending or active is ignored.
- FSM states: IDLE, DIV_Z, DIV_Y, SEND, RD_REQ, RD_SEND.
- IDLE:
  - If rd_pend is set and len_hold == 0: clear rd_pend and stay in IDLE.
  - Else if rd_pend is set: clear rd_pend, set idx=0, go to RD_REQ. Readout has priority over spikes; spikes wait in the FIFO.
  - Else if the FIFO is non-empty: rem = FIFO head, zc = 0, yc = 0, go to DIV_Z. The FIFO is not popped here.
- DIV_Z (one subtraction per cycle):
  - If xy_out != 0 and rem >= xy_out: rem -= xy_out, zc += 1.
  - Else go to DIV_Y.
- DIV_Y (one subtraction per cycle):
  - If x_out != 0 and rem >= x_out: rem -= x_out, yc += 1.
  - Else xc = rem, go to SEND.
- A zero divisor must never loop: the corresponding quotient is 0 and rem passes through unchanged.
- SEND:
  - spk_out_vld=1, spk_out_type=SPIKE.
  - spk_out_data = {zc, yc+y_start, xc+x_start}, each field truncated to SW/3 bits, with the sums wrapping modulo 2**(SW/3).
  - On spk_out_rdy: pop the FIFO, go to IDLE.
- RD_REQ:
  - out_soma_re=1 and out_soma_raddr=idx for exactly one cycle, then go to RD_SEND.
- RD_SEND:
  - On entry, register soma_out_rdata into the data hold register.
  - spk_out_vld=1, spk_out_data = the hold register.
  - spk_out_type = DATA_END when idx == len_hold-1, else DATA.
  - On spk_out_rdy: if last, go to IDLE; else idx += 1 and go to RD_REQ.
- Output handshake:
  - While spk_out_vld=1 and spk_out_rdy=0, spk_out_data and spk_out_type hold stable.
  - spk_out_vld drops to 0 the cycle after acceptance.
- Latency: an address below x_out pushed at cycle T is presented as a packet at T+4. Each extra subtraction adds 1 cycle.
- Config ports must remain stable while the FSM is outside IDLE.
- Reset mid-operation: the packet is abandoned, the FIFO is flushed, and nothing is replayed.

Test Plan:
- Spike decode: x_out=4, y_out=4, xy_out=16, x_start=2, y_start=1, addr=21, rdy=1 -> one packet, type 000, data 0x010203, vld at T+6.
- Backpressure: addr=0, rdy=0 for 5 cycles -> vld held with data 0x000102 stable; one accept on rdy; FIFO is empty afterwards.
- Overflow: 9 back-to-back events with rdy=0 -> spk_busy asserts after the 8th; 9th dropped; spk_ovf=1; after releasing rdy, exactly 8 packets in push order.
- Readout: rd_start with rd_len=3, rdata = addr+0x100 -> re pulses at addresses 0, 1, 2; packets 0x000100/DATA, 0x000101/DATA, 0x000102/DATA_END.
- Priority / zero-length: rd_start while 2 spikes are queued -> the readout packets are all sent before either spike. rd_start with rd_len=0 -> no packet and no re.
- Zero divisor: x_out=0, xy_out=0, addr=5, offsets 0 -> terminates with data 0x000005; asserting rst_n low mid-SEND clears vld and empties the FIFO.
